// File: rtl/mac_accumulator.sv
// mac_accumulator
//   Multiply-accumulate back end for the 4x4 array multiplier. Takes a stream
//   of products over a valid/ready handshake. It sums a programmable number of
//   them (len, where 0 means 2^CNT_W) into an ACC_W-bit accumulator. The sum is
//   then presented on an output valid/ready handshake.
//
//   Build option: define MAC_SATURATE_EN to clamp the accumulator at
//   2^ACC_W-1 on carry-out. The default build wraps modulo 2^ACC_W. ovf is set
//   in both builds.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   clr         synchronous abort/clear; discards any partial or pending result
//   len         terms per accumulation, sampled on the first accepted product
//   prod_in     product from the multiplier (zero-extended)
//   prod_valid  prod_in valid
//   prod_ready  block accepts prod_in this cycle
//   acc_out     accumulated sum, stable while acc_valid=1
//   acc_valid   result available
//   acc_ready   consumer takes result
//   ovf         sticky overflow flag for the current accumulation
module mac_accumulator #(
  parameter int PROD_W = 8,
  parameter int ACC_W  = 12,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic [CNT_W-1:0]  len,
  input  logic [PROD_W-1:0] prod_in,
  input  logic              prod_valid,
  output logic              prod_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic              ovf
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t             state, state_nxt;
  logic [ACC_W-1:0]   acc, acc_nxt;
  logic [CNT_W:0]     cnt, cnt_nxt;     // one extra bit so 2^CNT_W is representable
  logic [CNT_W:0]     len_q, len_q_nxt;
  logic               ovf_q, ovf_nxt;

  logic               accept;
  logic [ACC_W-1:0]   prod_ext;
  logic [ACC_W:0]     sum;              // carry-out in the top bit
  logic [CNT_W:0]     len_eff;
  logic [CNT_W:0]     cnt_inc;

  // prod_ready is gated with rst_n so it is low during reset, not just after.
  assign prod_ready = rst_n & ~clr & (state != DONE);
  assign accept     = prod_valid & prod_ready;
  assign acc_valid  = (state == DONE);
  assign acc_out    = acc;
  assign ovf        = ovf_q;

  assign prod_ext = ACC_W'(prod_in);
  assign sum      = {1'b0, acc} + {1'b0, prod_ext};
  assign cnt_inc  = cnt + (CNT_W+1)'(1);

  always_comb begin
    len_eff = {1'b0, len};
    if (len == '0) len_eff = {1'b1, {CNT_W{1'b0}}};
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    len_q_nxt = len_q;
    ovf_nxt   = ovf_q;
    if (clr) begin
      state_nxt = IDLE;
      acc_nxt   = '0;
      cnt_nxt   = '0;
      ovf_nxt   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            acc_nxt   = prod_ext;
            cnt_nxt   = (CNT_W+1)'(1);
            len_q_nxt = len_eff;
            ovf_nxt   = 1'b0;
            state_nxt = (len_eff == (CNT_W+1)'(1)) ? DONE : ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
`ifdef MAC_SATURATE_EN
            // Once clamped, later adds carry again (or add zero), so the
            // value stays pinned at full scale for the rest of the run.
            acc_nxt = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
            acc_nxt = sum[ACC_W-1:0];
`endif
            ovf_nxt = ovf_q | sum[ACC_W];
            cnt_nxt = cnt_inc;
            if (cnt_inc == len_q) state_nxt = DONE;
          end
        end
        DONE: begin
          // acc/ovf are held until the next accepted product.
          if (acc_ready) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      len_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      len_q <= len_q_nxt;
      ovf_q <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_mac_accumulator.sv
module tb_mac_accumulator;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic [4:0]  len;
  logic [7:0]  prod_in;
  logic        prod_valid;
  logic        prod_ready;
  logic [11:0] acc_out;
  logic        acc_valid;
  logic        acc_ready;
  logic        ovf;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct packed { logic [11:0] acc; logic ovf; } res_t;
  res_t exp_q[$];

  mac_accumulator dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .len(len), .prod_in(prod_in),
    .prod_valid(prod_valid), .prod_ready(prod_ready), .acc_out(acc_out),
    .acc_valid(acc_valid), .acc_ready(acc_ready), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Monitor: a result is consumed at the next rising edge when valid&ready.
  always @(negedge clk) begin
    if (rst_n && acc_valid && acc_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_result: got acc_out %0d expected none", acc_out);
      end else begin
        res_t e;
        e = exp_q.pop_front();
        chk("result_acc", 32'(acc_out), 32'(e.acc));
        chk("result_ovf", 32'(ovf), 32'(e.ovf));
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // Offer one product and hold it until accepted (bounded).
  task automatic send(input logic [7:0] p);
    logic took;
    int   n;
    prod_valid = 1'b1;
    prod_in    = p;
    took = 1'b0;
    n    = 0;
    while (!took && n < 50) begin
      @(negedge clk);
      took = prod_ready;
      cyc();
      n++;
    end
    prod_valid = 1'b0;
    if (!took) begin
      n_chk++;
      $display("FAIL send_timeout: got no accept expected accept of %0d", p);
    end
  endtask

  localparam logic [11:0] FULL_SUM =
`ifdef MAC_SATURATE_EN
    12'd4095;
`else
    12'd4064;
`endif

  initial begin
    rst_n = 1'b0; clr = 1'b0; len = '0; prod_in = '0;
    prod_valid = 1'b1; acc_ready = 1'b0;
    #3;
    chk("rst_acc_out",    32'(acc_out),    0);
    chk("rst_acc_valid",  32'(acc_valid),  0);
    chk("rst_prod_ready", 32'(prod_ready), 0);
    prod_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    cyc();
    chk("idle_prod_ready", 32'(prod_ready), 1);
    chk("idle_ovf",        32'(ovf),        0);
    chk("idle_acc_valid",  32'(acc_valid),  0);

    // len=3, back-to-back 225s, consumer ready
    acc_ready = 1'b1; len = 5'd3;
    exp_q.push_back('{12'd675, 1'b0});
    send(8'd225); send(8'd225); send(8'd225);
    chk("t2_valid_on_last_accept", 32'(acc_valid), 1);
    cyc();
    chk("t2_back_to_idle", 32'(acc_valid), 0);
    chk("t2_ready_again",  32'(prod_ready), 1);

    // len=2 with a gap; result held while consumer stalls
    acc_ready = 1'b0; len = 5'd2;
    exp_q.push_back('{12'd30, 1'b0});
    send(8'd10);
    len = 5'd7;                        // mid-run change must be ignored
    repeat (4) cyc();
    chk("t3_gap_no_valid", 32'(acc_valid), 0);
    send(8'd20);
    prod_valid = 1'b1; prod_in = 8'd99;
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_valid", 32'(acc_valid),  1);
      chk("t3_hold_acc",   32'(acc_out),    30);
      chk("t3_hold_ready", 32'(prod_ready), 0);
      cyc();
    end
    prod_valid = 1'b0; acc_ready = 1'b1;
    cyc();
    acc_ready = 1'b0;
    chk("t3_consumed", 32'(acc_valid), 0);
    chk("t3_acc_kept", 32'(acc_out),   30);

    // len=0 -> 32 terms of 255; overflow on the 17th add
    acc_ready = 1'b1; len = 5'd0;
    exp_q.push_back('{FULL_SUM, 1'b1});
    for (int i = 0; i < 16; i++) send(8'd255);
    chk("t4_16_acc", 32'(acc_out), 4080);
    chk("t4_16_ovf", 32'(ovf),     0);
    send(8'd255);
    chk("t4_17_ovf",   32'(ovf),       1);
    chk("t4_17_valid", 32'(acc_valid), 0);
    for (int i = 0; i < 15; i++) send(8'd255);
    chk("t4_valid", 32'(acc_valid), 1);
    cyc();

    // clr mid-accumulation, then a single-term run
    len = 5'd4;
    send(8'd50); send(8'd60);
    clr = 1'b1; prod_valid = 1'b1; prod_in = 8'd70;
    #1;
    chk("t5_clr_blocks_ready", 32'(prod_ready), 0);
    cyc();
    clr = 1'b0; prod_valid = 1'b0;
    chk("t5_clr_acc",   32'(acc_out),   0);
    chk("t5_clr_valid", 32'(acc_valid), 0);
    chk("t5_clr_ovf",   32'(ovf),       0);
    len = 5'd1;
    exp_q.push_back('{12'd7, 1'b0});
    send(8'd7);
    chk("t5_len1_valid", 32'(acc_valid), 1);
    cyc();

    // async reset while a result waits in DONE
    acc_ready = 1'b0; len = 5'd3;
    send(8'd225); send(8'd225); send(8'd225);
    chk("t6_done_acc", 32'(acc_out), 675);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_acc",   32'(acc_out),   0);
    chk("t6_rst_valid", 32'(acc_valid), 0);
    chk("t6_rst_ready", 32'(prod_ready), 0);
    #2 rst_n = 1'b1;
    cyc();
    acc_ready = 1'b1; len = 5'd2;
    exp_q.push_back('{12'd3, 1'b0});
    send(8'd1); send(8'd2);
    cyc(); cyc();

    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mac_accumulator.md
Name: mac_accumulator

Overview:
- Sequential stage directly downstream of the 4x4 array multiplier.
- Accepts a stream of 8-bit products through a valid/ready handshake and sums a programmable number of them into a wide accumulator.
- Presents the sum on an output handshake, turning the combinational multiplier into a multiply-accumulate datapath.
- Output fits the 16 tile output pins: acc_out plus status flags.

Parameters:
PROD_W, 8, product input width (multiplier output width)
ACC_W, 12, accumulator width; sums wrap or saturate at 2^ACC_W
CNT_W, 5, term-counter width; up to 2^CNT_W products per accumulation

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
clr  input  1  synchronous abort/clear, highest priority after reset
len  input  CNT_W  terms per accumulation, sampled on first accepted product; 0 means 2^CNT_W
prod_in  input  PROD_W  product from multiplier, zero-extended to ACC_W
prod_valid  input  1  prod_in valid
prod_ready  output  1  block accepts prod_in this cycle
acc_out  output  ACC_W  accumulated sum, stable while acc_valid=1
acc_valid  output  1  result available
acc_ready  input  1  consumer takes result
ovf  output  1  sticky overflow flag for the current accumulation

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately):
  - acc=0, cnt=0, len_q=0, ovf=0, state=IDLE.
  - Outputs: acc_out=0, acc_valid=0, prod_ready=0 while rst_n=0.
- Transfer rules:
  - Product accepted when prod_valid & prod_ready at a rising edge.
  - Result consumed when acc_valid & acc_ready.
- States:
  - IDLE:
    - prod_ready=~clr.
    - On accept: acc<=prod_in, cnt<=1, len_q<=(len==0 ? 2^CNT_W : len), ovf<=0.
    - If the effective len is 1, go to DONE; otherwise go to ACCUM.
  - ACCUM:
    - prod_ready=~clr.
    - On accept: acc<=acc+prod_in, computed at ACC_W+1 bits; carry-out sets ovf (sticky); cnt<=cnt+1.
    - If cnt+1==len_q, go to DONE.
    - prod_valid low means hold: no state change; gaps are unlimited.
  - DONE:
    - prod_ready=0, acc_valid=1, acc_out=acc, held stable.
    - On acc_ready, go to IDLE next cycle with acc_valid=0.
    - acc and ovf retain their values until the next accepted product.
- Latency:
  - acc_valid rises on the clock edge that accepts the final product.
  - A new accumulation may start the cycle after the result is consumed; there is no same-cycle consume-and-start.
- clr (synchronous):
  - Any state goes to IDLE; acc=0, cnt=0, ovf=0, acc_valid=0.
  - A product presented the same cycle is not accepted (prod_ready=0).
  - clr in DONE discards an unconsumed result.
- len changes mid-accumulation have no effect; only len_q is used.
- Counter: cnt is CNT_W+1 bits so that len_q=2^CNT_W is representable; no wrap.
- ovf is visible immediately after the overflowing add, also during ACCUM.

Optional Feature:
- Macro: MAC_SATURATE_EN.
- Defined:
  - On carry-out, acc clamps to 2^ACC_W-1.
  - Once clamped, acc stays at 2^ACC_W-1 for the rest of that accumulation.
  - ovf is set as usual.
- Undefined:
  - acc wraps modulo 2^ACC_W.
  - ovf is still set.
- Handshake timing is identical in both builds.

Test Plan:
- Reset, then idle -> acc_out=0, acc_valid=0, ovf=0; prod_ready=1 after rst_n rises.
- len=3, prod_in 225,225,225 on consecutive cycles -> acc_valid=1 on the 3rd accept edge, acc_out=675, ovf=0; acc_ready=1 -> IDLE next cycle.
- len=2, prod_in 10, then 4 idle cycles, then 20; acc_ready held low 5 cycles -> acc_out=30 stable, prod_ready=0 throughout DONE, extra product offered during DONE not consumed.
- len=0 (32 terms), 32x prod_in=255 -> without MAC_SATURATE_EN acc_out=4064, ovf=1; with it acc_out=4095, ovf=1.
- len=4, accept 50, 60, assert clr with prod_valid=1 -> IDLE, acc=0, that product not accepted; then len=1, prod_in=7 -> acc_out=7, ovf=0.
- rst_n low asynchronously while in DONE with acc_out=675 -> acc_out=0, acc_valid=0 before the next clock edge; normal operation after release.
